// File: rtl/seg_pkg.sv
// Shared seven-segment definitions for the serial segment link (rx and tx).
// Byte layout on the wire is {dp,g,f,e,d,c,b,a}, active-low (0 = lit).
package seg_pkg;

  // Bit positions of each segment inside a wire byte
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high gfedcba glyphs; entry k is the glyph for hex digit k.
  // Packed array literal lists index 15 first.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Wire byte (active-low) for a hex digit with an optional decimal point
  function automatic logic [7:0] glyph_encode(input logic [3:0] nib, input logic dp);
    return ~{dp, GLYPH_TABLE[nib]};
  endfunction

endpackage

// File: rtl/seg_glyph_dec.sv
// Decodes one active-low segment byte to a hex nibble; dp is ignored.
// Non-matching bytes give nibble 0 with ok low.
module seg_glyph_dec
  import seg_pkg::*;
(
  input  logic [7:0] seg_byte,
  output logic [3:0] nibble,
  output logic       ok
);

  logic [7:0] lit;

  // Invert to active-high and drop dp so only gfedcba take part in matching
  assign lit = ~seg_byte & ~(8'h01 << SEG_DP);

  // Search the glyph table; entries are unique so at most one hit
  always_comb begin
    nibble = 4'h0;
    ok     = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (lit == {1'b0, GLYPH_TABLE[k[3:0]]}) begin
        nibble = k[3:0];
        ok     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_serial_rx.sv
// Receiver for a serial seven-segment frame: synchronizes the asynchronous
// shift-clock/clear/latch/data lines, shifts bits in MSB first, and on the
// latch strobe captures the frame and its decoded hex digits.
//
// Output handshake: frame_valid is a valid-only strobe (no ready). It is high
// for exactly one clk cycle, in the same cycle frame/hexs/digit_ok first show
// the new frame; those outputs then hold until the next good latch.
module seg_serial_rx
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    seg_clk,
  input  logic                    seg_clrn,
  input  logic                    seg_pen,
  input  logic                    seg_sout,
  output logic [8*NUM_DIGITS-1:0] frame,
  output logic [4*NUM_DIGITS-1:0] hexs,
  output logic [NUM_DIGITS-1:0]   digit_ok,
  output logic                    frame_valid,
  output logic                    frame_err
);

  localparam int FW    = 8 * NUM_DIGITS;
  localparam int CNT_W = $clog2(FW + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FW);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FW + 1);

  // Synchronizer lanes: bit 0 seg_clk, 1 seg_clrn, 2 seg_pen, 3 seg_sout
  logic [3:0] sync_q [SYNC_STAGES];
  logic       clk_s, clrn_s, pen_s, sout_s;
  logic       clk_prev, pen_prev;
  logic       clk_rise, pen_rise;

  logic [FW-1:0]         shift_q, shift_next;
  logic [CNT_W-1:0]      cnt_q, cnt_next;
  logic [4*NUM_DIGITS-1:0] dec_hexs;
  logic [NUM_DIGITS-1:0]   dec_ok;
  logic                    latch_good;

  // Multi-stage synchronizer for all four serial-side inputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= 4'b0000;
    end else begin
      sync_q[0] <= {seg_sout, seg_pen, seg_clrn, seg_clk};
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign clk_s  = sync_q[SYNC_STAGES-1][0];
  assign clrn_s = sync_q[SYNC_STAGES-1][1];
  assign pen_s  = sync_q[SYNC_STAGES-1][2];
  assign sout_s = sync_q[SYNC_STAGES-1][3];

  // Previous synchronized levels for rising-edge detection; tracked even
  // during clear so an edge seen while cleared is not replayed afterwards
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_prev <= 1'b0;
      pen_prev <= 1'b0;
    end else begin
      clk_prev <= clk_s;
      pen_prev <= pen_s;
    end
  end

  assign clk_rise = clk_s & ~clk_prev;
  assign pen_rise = pen_s & ~pen_prev;

  // Shift is applied before the latch looks at the count, so a coincident
  // last bit and latch strobe still forms a complete frame
  always_comb begin
    shift_next = shift_q;
    cnt_next   = cnt_q;
    if (clk_rise) begin
      shift_next = {shift_q[FW-2:0], sout_s};
      if (cnt_q != CNT_MAX) cnt_next = cnt_q + 1'b1;
    end
  end

  assign latch_good = pen_rise && (cnt_next == CNT_FULL);

  // Decode the post-shift image so hexs lands in the same cycle as frame
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
    seg_glyph_dec u_dec (
      .seg_byte (shift_next[8*i +: 8]),
      .nibble   (dec_hexs[4*i +: 4]),
      .ok       (dec_ok[i])
    );
  end

  // Shift register and bit counter; clear wins over shift and latch
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (!clrn_s) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_next;
      cnt_q   <= pen_rise ? '0 : cnt_next;
    end
  end

  // Output latch: capture on a good strobe, flag a bad bit count otherwise
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame       <= '1;
      hexs        <= '0;
      digit_ok    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (clrn_s && pen_rise) begin
        if (latch_good) begin
          frame       <= shift_next;
          hexs        <= dec_hexs;
          digit_ok    <= dec_ok;
          frame_valid <= 1'b1;
          frame_err   <= 1'b0;
        end else begin
          frame_err   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_serial_rx.sv
// Testbench for seg_serial_rx: directed scenarios plus randomized frames,
// checked against a bit-queue reference model and an expected-frame queue.
module tb_seg_serial_rx;

  localparam int N  = 8;
  localparam int FW = 8 * N;
  localparam int W  = FW + 4 * N + N;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          seg_clk = 1'b0;
  logic          seg_clrn = 1'b1;
  logic          seg_pen = 1'b0;
  logic          seg_sout = 1'b0;
  logic [FW-1:0] frame;
  logic [4*N-1:0] hexs;
  logic [N-1:0]  digit_ok;
  logic          frame_valid;
  logic          frame_err;

  seg_serial_rx #(.NUM_DIGITS(N), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .seg_clk     (seg_clk),
    .seg_clrn    (seg_clrn),
    .seg_pen     (seg_pen),
    .seg_sout    (seg_sout),
    .frame       (frame),
    .hexs        (hexs),
    .digit_ok    (digit_ok),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL timeout: bench did not finish within 3 ms");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: bits received since the last clear/latch, plus the
  // externally visible latched state
  logic          m_bits[$];
  int            m_cnt;
  logic          m_clrn;
  logic [FW-1:0] m_frame;
  logic [4*N-1:0] m_hexs;
  logic [N-1:0]  m_ok;
  logic          m_err;

  // Active-high gfedcba glyph for each hex digit
  logic [6:0] ref_glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] enc_byte(input logic [3:0] d, input logic dp);
    logic [7:0] lit;
    lit = {dp, ref_glyph[d]};
    return ~lit;
  endfunction

  function automatic logic [FW-1:0] enc_frame(input logic [4*N-1:0] hx, input logic [N-1:0] dp);
    logic [FW-1:0] f;
    for (int i = 0; i < N; i++) f[8*i +: 8] = enc_byte(hx[4*i +: 4], dp[i]);
    return f;
  endfunction

  task automatic decode_ref(input logic [7:0] b, output logic [3:0] n, output logic ok);
    n = 4'h0;
    ok = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (~b[6:0] == ref_glyph[k]) begin
        n = 4'(k);
        ok = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_cnt   = 0;
    m_frame = '1;
    m_hexs  = '0;
    m_ok    = '0;
    m_err   = 1'b0;
  endtask

  task automatic model_latch();
    logic [3:0] n;
    logic ok;
    if (m_cnt == FW) begin
      for (int i = 0; i < FW; i++) m_frame[FW-1-i] = m_bits[m_bits.size() - FW + i];
      for (int i = 0; i < N; i++) begin
        decode_ref(m_frame[8*i +: 8], n, ok);
        m_hexs[4*i +: 4] = n;
        m_ok[i] = ok;
      end
      m_err = 1'b0;
      exp_q.push_back({m_frame, m_hexs, m_ok});
    end else begin
      m_err = 1'b1;
    end
    m_cnt = 0;
    m_bits.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    seg_sout = b;
    wait_clk(3);
    seg_clk = 1'b1;
    if (m_clrn) begin
      m_bits.push_back(b);
      if (m_cnt < FW + 1) m_cnt++;
    end
    wait_clk(4);
    seg_clk = 1'b0;
    wait_clk(3);
  endtask

  task automatic pulse_pen();
    seg_pen = 1'b1;
    if (m_clrn) model_latch();
    wait_clk(4);
    seg_pen = 1'b0;
    wait_clk(6);
  endtask

  // Final bit's clock edge and the latch strobe rise together
  task automatic send_last_with_pen(input logic b);
    seg_sout = b;
    wait_clk(3);
    seg_clk = 1'b1;
    seg_pen = 1'b1;
    m_bits.push_back(b);
    if (m_cnt < FW + 1) m_cnt++;
    model_latch();
    wait_clk(4);
    seg_clk = 1'b0;
    seg_pen = 1'b0;
    wait_clk(6);
  endtask

  task automatic clear_pulse(input logic pen_during);
    seg_clrn = 1'b0;
    m_clrn = 1'b0;
    m_bits.delete();
    m_cnt = 0;
    wait_clk(5);
    if (pen_during) pulse_pen();
    seg_clrn = 1'b1;
    m_clrn = 1'b1;
    wait_clk(4);
  endtask

  // Sends the first nbits of f (MSB first); bits beyond FW are random
  task automatic send_frame(input logic [FW-1:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (i < FW) send_bit(f[FW-1-i]);
      else        send_bit(1'($urandom_range(0, 1)));
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    wait_clk(3);
    @(negedge clk);
    check("rst_frame", frame, {FW{1'b1}});
    check("rst_hexs", hexs, 0);
    check("rst_digit_ok", digit_ok, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_frame_err", frame_err, 0);
    wait_clk(1);
    rstn = 1'b1;
    wait_clk(4);
  endtask

  task automatic check_outputs(input string name);
    wait_clk(2);
    @(negedge clk);
    check({name, "_frame"}, frame, m_frame);
    check({name, "_hexs"}, hexs, m_hexs);
    check({name, "_digit_ok"}, digit_ok, m_ok);
    check({name, "_frame_err"}, frame_err, m_err);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rstn && frame_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_frame_valid: got frame %0h with no frame expected", frame);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({frame, hexs, digit_ok} !== e || frame_err !== 1'b0) begin
          fails++;
          $display("FAIL valid_frame: got %0h err %0b expected %0h err 0",
                   {frame, hexs, digit_ok}, frame_err, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [FW-1:0] f;
    logic [4*N-1:0] hx;
    m_clrn = 1'b1;
    model_reset();
    do_reset();

    // Good frame 0x12345678
    send_frame(enc_frame(32'h12345678, 8'h00), FW);
    pulse_pen();
    check_outputs("good_12345678");
    check("good_hexs_const", hexs, 32'h12345678);
    check("good_ok_const", digit_ok, 8'hFF);

    // Short frame: error, outputs unchanged
    send_frame(enc_frame(32'hCAFE0123, 8'h00), FW - 1);
    pulse_pen();
    check_outputs("short_63");
    check("short_err_const", frame_err, 1);

    // Partial frame, clear, then good frame clears the error
    send_frame(enc_frame(32'h55555555, 8'h00), 40);
    clear_pulse(1'b0);
    send_frame(enc_frame(32'hDEADBEEF, 8'h5A), FW);
    pulse_pen();
    check_outputs("clr_deadbeef");
    check("clr_hexs_const", hexs, 32'hDEADBEEF);

    // Blank byte 0 in an otherwise valid frame
    f = enc_frame(32'h9ABCDEF0, 8'h00);
    f[7:0] = 8'hFF;
    send_frame(f, FW);
    pulse_pen();
    check_outputs("blank_byte0");
    check("blank_ok0_const", digit_ok[0], 0);

    // Reset mid-frame, then a full frame
    send_frame(enc_frame(32'h13579BDF, 8'h00), 30);
    do_reset();
    send_frame(enc_frame(32'h2468ACE0, 8'hFF), FW);
    pulse_pen();
    check_outputs("post_reset");

    // Last clock edge coincident with the latch strobe
    f = enc_frame(32'h0F1E2D3C, 8'h00);
    send_frame(f, FW - 1);
    send_last_with_pen(f[0]);
    check_outputs("coincident");

    // Latch strobe while cleared is ignored; then strobe with zero bits errors
    send_frame(enc_frame(32'h11112222, 8'h00), FW);
    clear_pulse(1'b1);
    check_outputs("pen_in_clear");
    pulse_pen();
    check_outputs("pen_zero_bits");

    // Randomized frames: illegal bytes, wrong lengths, mid-frame clears
    for (int it = 0; it < 16; it++) begin
      int nbits;
      hx = 32'($urandom);
      f = enc_frame(hx, 8'($urandom));
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) f[8*i +: 8] = 8'($urandom);
      nbits = ($urandom_range(0, 3) == 0) ? $urandom_range(FW - 6, FW + 4) : FW;
      if ($urandom_range(0, 5) == 0) begin
        send_frame(f, $urandom_range(1, 20));
        clear_pulse(1'b0);
      end
      send_frame(f, nbits);
      pulse_pen();
      check_outputs($sformatf("rand%0d", it));
    end

    wait_clk(5);
    check("pending_frames", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
